// File: rtl/alu_issue_unit_pkg.sv
// Package: alu_issue_unit_pkg
// Shared definitions for the ALU issue unit:
//   - ALU opcode encodings carried in the top three instruction bits
//   - bit positions of the instruction fields
//   - FSM state encoding
//   - helper that tells a dispatchable opcode from a reserved one
package alu_issue_unit_pkg;

    // ALU opcodes (instr[31:29])
    localparam logic [2:0] OP_RSV0 = 3'b000;
    localparam logic [2:0] OP_RSV1 = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_EQ   = 3'b011;
    localparam logic [2:0] OP_SHL  = 3'b100;
    localparam logic [2:0] OP_SHR  = 3'b101;
    localparam logic [2:0] OP_ADDI = 3'b110;
    localparam logic [2:0] OP_SUBI = 3'b111;

    // Instruction field positions
    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 29;
    localparam int RD_MSB  = 28;
    localparam int RD_LSB  = 26;
    localparam int RS1_MSB = 25;
    localparam int RS1_LSB = 23;
    localparam int RS2_MSB = 22;
    localparam int RS2_LSB = 20;
    localparam int IMM_MSB = 19;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = IMM_MSB - IMM_LSB + 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DECODE    = 2'd1,
        ST_EXECUTE   = 2'd2,
        ST_WRITEBACK = 2'd3
    } state_t;

    // Opcodes 000/001 are reserved and get dropped in DECODE.
    function automatic logic is_legal_op(input logic [2:0] op);
        return op[2:1] != 2'b00;
    endfunction

    // ADDI/SUBI take operand B from the immediate instead of rs2.
    function automatic logic uses_imm(input logic [2:0] op);
        return op[2:1] == 2'b11;
    endfunction

endpackage

// File: rtl/alu_issue_unit_if.sv
// Interface: alu_issue_unit_if
// Bundles the instruction handshake, the ALU operand/result bus and the
// writeback/status pulses of the issue unit.
//   master : the surrounding block (instruction source + combinational ALU)
//   slave  : the issue unit itself
interface alu_issue_unit_if #(
    parameter int DATA_W = 32
);
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [2:0]        alu_op;
    logic [DATA_W-1:0] alu_result;
    logic              done_valid;
    logic [2:0]        done_rd;
    logic [DATA_W-1:0] done_value;
    logic              illegal;

    modport master (
        output instr_valid, instr, alu_result,
        input  instr_ready, alu_a, alu_b, alu_op,
               done_valid, done_rd, done_value, illegal
    );

    modport slave (
        input  instr_valid, instr, alu_result,
        output instr_ready, alu_a, alu_b, alu_op,
               done_valid, done_rd, done_value, illegal
    );
endinterface

// File: rtl/alu_issue_unit_reg_file.sv
// Module: alu_issue_unit_reg_file
// 8 x DATA_W register file: three asynchronous read ports (rs1, rs2, debug),
// one synchronous write port, synchronous clear to zero.
// With ZERO_REG=1, R0 always reads zero and writes to it are discarded.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   we, waddr, wdata    write port (takes effect at the clock edge)
//   raddr1/rdata1       read port 1 (rs1)
//   raddr2/rdata2       read port 2 (rs2)
//   raddr3/rdata3       read port 3 (debug)
module alu_issue_unit_reg_file #(
    parameter int DATA_W   = 32,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [2:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [2:0]        raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic [2:0]        raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic [2:0]        raddr3,
    output logic [DATA_W-1:0] rdata3
);
    // Asynchronous reads rule out a block RAM here; each entry is a flop.
    logic [DATA_W-1:0] rf_arr [8];

    for (genvar gi = 0; gi < 8; gi++) begin : g_reg
        localparam bit WRITABLE = !(ZERO_REG && (gi == 0));
        logic [DATA_W-1:0] q_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                q_reg <= '0;
            end else if (WRITABLE && we && (waddr == 3'(gi))) begin
                q_reg <= wdata;
            end
        end

        assign rf_arr[gi] = q_reg;
    end

    function automatic logic [DATA_W-1:0] rd_port(input logic [2:0] a,
                                                  input logic [DATA_W-1:0] v);
        return (ZERO_REG && (a == 3'd0)) ? '0 : v;
    endfunction

    assign rdata1 = rd_port(raddr1, rf_arr[raddr1]);
    assign rdata2 = rd_port(raddr2, rf_arr[raddr2]);
    assign rdata3 = rd_port(raddr3, rf_arr[raddr3]);

endmodule

// File: rtl/alu_issue_unit.sv
// Module: alu_issue_unit
// Non-pipelined issue stage in front of a combinational ALU. One instruction
// per handshake, four cycles each: IDLE -> DECODE -> EXECUTE -> WRITEBACK.
// Instruction: [31:29] op, [28:26] rd, [25:23] rs1, [22:20] rs2, [19:0] imm.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   bus (slave)      instr_valid/instr_ready/instr handshake,
//                    alu_a/alu_b/alu_op out, alu_result in,
//                    done_valid/done_rd/done_value writeback pulse,
//                    illegal pulse for dropped reserved opcodes
//   busy             high whenever not in IDLE
//   dbg_addr/data    asynchronous register-file peek
module alu_issue_unit
    import alu_issue_unit_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    alu_issue_unit_if.slave   bus,
    output logic              busy,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    state_t            state_reg, state_next;
    logic [31:0]       instr_reg;
    logic [DATA_W-1:0] alu_a_reg;
    logic [DATA_W-1:0] alu_b_reg;
    logic [2:0]        alu_op_reg;
    logic [DATA_W-1:0] result_reg;
    logic              illegal_reg;

    logic [2:0]        op_f, rd_f, rs1_f, rs2_f;
    logic [IMM_W-1:0]  imm_f;
    logic [DATA_W-1:0] rs1_data, rs2_data;
    logic              accept;
    logic              wb_en;

    assign op_f  = instr_reg[OP_MSB:OP_LSB];
    assign rd_f  = instr_reg[RD_MSB:RD_LSB];
    assign rs1_f = instr_reg[RS1_MSB:RS1_LSB];
    assign rs2_f = instr_reg[RS2_MSB:RS2_LSB];
    assign imm_f = instr_reg[IMM_MSB:IMM_LSB];

    assign accept = bus.instr_valid && (state_reg == ST_IDLE);
    assign wb_en  = (state_reg == ST_WRITEBACK);

    alu_issue_unit_reg_file #(
        .DATA_W  (DATA_W),
        .ZERO_REG(ZERO_REG)
    ) u_rf (
        .clk   (clk),
        .rst   (rst),
        .we    (wb_en),
        .waddr (rd_f),
        .wdata (result_reg),
        .raddr1(rs1_f),
        .rdata1(rs1_data),
        .raddr2(rs2_f),
        .rdata2(rs2_data),
        .raddr3(dbg_addr),
        .rdata3(dbg_data)
    );

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE:      if (bus.instr_valid) state_next = ST_DECODE;
            ST_DECODE:    state_next = is_legal_op(op_f) ? ST_EXECUTE : ST_IDLE;
            ST_EXECUTE:   state_next = ST_WRITEBACK;
            ST_WRITEBACK: state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            instr_reg   <= '0;
            alu_a_reg   <= '0;
            alu_b_reg   <= '0;
            alu_op_reg  <= '0;
            result_reg  <= '0;
            illegal_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            // Pulse lands in the IDLE cycle right after the dropping DECODE.
            illegal_reg <= (state_reg == ST_DECODE) && !is_legal_op(op_f);

            if (accept) begin
                instr_reg <= bus.instr;
            end

            // Operands only move on a legal DECODE, so they hold steady
            // through EXECUTE and keep their last values afterwards.
            if ((state_reg == ST_DECODE) && is_legal_op(op_f)) begin
                alu_a_reg  <= rs1_data;
                alu_b_reg  <= uses_imm(op_f) ? DATA_W'(imm_f) : rs2_data;
                alu_op_reg <= op_f;
            end

            if (state_reg == ST_EXECUTE) begin
                result_reg <= bus.alu_result;
            end
        end
    end

    assign bus.instr_ready = (state_reg == ST_IDLE);
    assign busy            = (state_reg != ST_IDLE);
    assign bus.alu_a       = alu_a_reg;
    assign bus.alu_b       = alu_b_reg;
    assign bus.alu_op      = alu_op_reg;
    assign bus.illegal     = illegal_reg;
    assign bus.done_valid  = wb_en;
    assign bus.done_rd     = wb_en ? rd_f : 3'd0;
    assign bus.done_value  = wb_en ? result_reg : '0;

endmodule

// File: tb/tb_alu_issue_unit.sv
module tb_alu_issue_unit;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          busy;
    logic [2:0]    dbg_addr;
    logic [DW-1:0] dbg_data;

    always #5 clk = ~clk;

    alu_issue_unit_if #(.DATA_W(DW)) bus ();

    alu_issue_unit #(.DATA_W(DW), .ZERO_REG(1'b1)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .busy    (busy),
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data)
    );

    // Combinational ALU owned by the parent.
    always_comb begin
        case (bus.alu_op)
            3'b010:  bus.alu_result = bus.alu_a + bus.alu_b;
            3'b011:  bus.alu_result = {31'd0, bus.alu_a == bus.alu_b};
            3'b100:  bus.alu_result = bus.alu_a << bus.alu_b;
            3'b101:  bus.alu_result = bus.alu_a >> bus.alu_b;
            3'b110:  bus.alu_result = bus.alu_a + bus.alu_b;
            3'b111:  bus.alu_result = bus.alu_a - bus.alu_b;
            default: bus.alu_result = '0;
        endcase
    end

    // Reference architectural state: R0 is hard-wired zero.
    logic [31:0] model_rf [8];
    int n_vec = 0;
    int n_err = 0;

    function automatic logic [31:0] mk(input int op, input int rd, input int rs1,
                                       input int rs2, input int imm);
        logic [31:0] w;
        w = {3'(op), 3'(rd), 3'(rs1), 3'(rs2), 20'(imm)};
        return w;
    endfunction

    function automatic logic [31:0] mreg(input logic [2:0] r);
        return (r == 3'd0) ? 32'd0 : model_rf[r];
    endfunction

    // What the instruction should produce, straight from the ISA rules.
    function automatic logic [31:0] ref_value(input logic [31:0] w);
        logic [31:0] x, y, imm;
        x   = mreg(w[25:23]);
        y   = mreg(w[22:20]);
        imm = {12'd0, w[19:0]};
        case (w[31:29])
            3'd2:    return x + y;
            3'd3:    return (x == y) ? 32'd1 : 32'd0;
            3'd4:    return (y >= 32) ? 32'd0 : x * (32'd1 << y);
            3'd5:    return (y >= 32) ? 32'd0 : x / (32'd1 << y);
            3'd6:    return x + imm;
            3'd7:    return x - imm;
            default: return 32'd0;
        endcase
    endfunction

    // Issue one word and watch it for up to six cycles. Entered and left at a
    // negative edge; lat counts cycles after the accepting edge.
    task automatic send(input logic [31:0] w, output int lat, output logic [2:0] rd_o,
                        output logic [31:0] val_o, output logic ill_o,
                        output logic [31:0] xa, output logic [31:0] xb,
                        output logic [2:0] xop);
        int waitc;
        waitc = 0;
        lat = 0; rd_o = 0; val_o = 0; ill_o = 0; xa = 0; xb = 0; xop = 0;
        while (bus.instr_ready !== 1'b1 && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        if (bus.instr_ready !== 1'b1) begin
            n_vec++; n_err++;
            $display("FAIL ready_timeout: ready=%b required 1", bus.instr_ready);
            return;
        end
        bus.instr       = w;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        bus.instr       = $urandom;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 2) begin
                xa = bus.alu_a; xb = bus.alu_b; xop = bus.alu_op;
            end
            if (bus.done_valid === 1'b1) begin
                lat = k; rd_o = bus.done_rd; val_o = bus.done_value;
                break;
            end
            if (bus.illegal === 1'b1) begin
                lat = k; ill_o = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_regs(input string tag);
        for (int r = 0; r < 8; r++) begin
            dbg_addr = 3'(r);
            #1;
            n_vec++;
            if (dbg_data !== mreg(3'(r))) begin
                n_err++;
                $display("FAIL %s_dbg_R%0d: got %h required %h", tag, r, dbg_data, mreg(3'(r)));
            end
        end
    endtask

    // Issue a legal instruction and check everything it should do.
    task automatic exec(input logic [31:0] w, input string tag);
        int lat; logic [2:0] rd_o; logic [31:0] val_o, xa, xb, exp_v, exp_a, exp_b;
        logic ill_o; logic [2:0] xop;
        exp_v = ref_value(w);
        exp_a = mreg(w[25:23]);
        exp_b = (w[31:30] == 2'b11) ? {12'd0, w[19:0]} : mreg(w[22:20]);
        send(w, lat, rd_o, val_o, ill_o, xa, xb, xop);
        $display("txn %s op=%0d rd=%0d rs1=%0d rs2=%0d imm=%h -> rd=%0d val=%h lat=%0d",
                 tag, w[31:29], w[28:26], w[25:23], w[22:20], w[19:0], rd_o, val_o, lat);
        n_vec++;
        if (lat !== 3) begin
            n_err++; $display("FAIL %s_latency: got %0d required 3", tag, lat);
        end
        n_vec++;
        if (rd_o !== w[28:26]) begin
            n_err++; $display("FAIL %s_done_rd: got %0d required %0d", tag, rd_o, w[28:26]);
        end
        n_vec++;
        if (val_o !== exp_v) begin
            n_err++; $display("FAIL %s_done_value: got %h required %h", tag, val_o, exp_v);
        end
        n_vec++;
        if (xa !== exp_a || xb !== exp_b || xop !== w[31:29]) begin
            n_err++;
            $display("FAIL %s_alu_operands: got a=%h b=%h op=%0d required a=%h b=%h op=%0d",
                     tag, xa, xb, xop, exp_a, exp_b, w[31:29]);
        end
        if (w[28:26] != 3'd0) model_rf[w[28:26]] = exp_v;
        @(negedge clk);
        dbg_addr = w[28:26];
        #1;
        n_vec++;
        if (dbg_data !== mreg(w[28:26])) begin
            n_err++;
            $display("FAIL %s_dbg_rd: got %h required %h", tag, dbg_data, mreg(w[28:26]));
        end
    endtask

    task automatic test_reset();
        bus.instr_valid = 1'b0; bus.instr = '0; dbg_addr = '0; rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int r = 0; r < 8; r++) model_rf[r] = 32'd0;
        n_vec++;
        if (bus.instr_ready !== 1'b1 || busy !== 1'b0 || bus.done_valid !== 1'b0 ||
            bus.illegal !== 1'b0 || bus.alu_a !== 0 || bus.alu_b !== 0 || bus.alu_op !== 0 ||
            bus.done_rd !== 0 || bus.done_value !== 0) begin
            n_err++;
            $display("FAIL reset_outputs: ready=%b busy=%b dv=%b ill=%b a=%h b=%h op=%0d drd=%0d dval=%h required ready=1 others 0",
                     bus.instr_ready, busy, bus.done_valid, bus.illegal, bus.alu_a, bus.alu_b,
                     bus.alu_op, bus.done_rd, bus.done_value);
        end
        check_regs("reset");
        @(negedge clk);
    endtask

    task automatic test_add();
        exec(mk(6, 1, 0, 0, 5), "addi_r1");
        exec(mk(6, 2, 0, 0, 7), "addi_r2");
        exec(mk(2, 3, 1, 2, 0), "add_r3");
    endtask

    task automatic test_subi_eq();
        exec(mk(7, 4, 1, 0, 8), "subi_r4");
        exec(mk(3, 5, 1, 1, 0), "eq_same");
        exec(mk(3, 5, 1, 4, 0), "eq_diff");
    endtask

    task automatic test_back_to_back();
        exec(mk(6, 1, 0, 0, 1), "addi_r1_1");
        exec(mk(6, 2, 0, 0, 4), "addi_r2_4");
        exec(mk(4, 6, 1, 2, 0), "shl_r6");
        exec(mk(5, 7, 6, 2, 0), "shr_dep_r6");
    endtask

    task automatic test_illegal();
        int lat; logic [2:0] rd_o; logic [31:0] val_o, xa, xb; logic ill_o; logic [2:0] xop;
        for (int op = 0; op < 2; op++) begin
            send(mk(op, 3, 1, 2, int'($urandom_range(0, 20'hFFFFF))), lat, rd_o, val_o, ill_o, xa, xb, xop);
            $display("txn illegal op=%0d -> illegal=%b lat=%0d", op, ill_o, lat);
            n_vec++;
            if (ill_o !== 1'b1 || lat !== 2) begin
                n_err++;
                $display("FAIL illegal%0d_pulse: got ill=%b lat=%0d required ill=1 lat=2", op, ill_o, lat);
            end
            n_vec++;
            if (bus.instr_ready !== 1'b1) begin
                n_err++; $display("FAIL illegal%0d_ready: got %b required 1", op, bus.instr_ready);
            end
            @(negedge clk);
            n_vec++;
            if (bus.illegal !== 1'b0 || bus.done_valid !== 1'b0) begin
                n_err++;
                $display("FAIL illegal%0d_after: got ill=%b dv=%b required 0 0", op, bus.illegal, bus.done_valid);
            end
            check_regs("illegal");
        end
    endtask

    task automatic test_r0_and_busy();
        exec(mk(6, 0, 0, 0, 9), "addi_r0");
        // Hold a second request up while the first is in flight.
        bus.instr       = mk(6, 1, 0, 0, 32'h11);
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.instr = mk(6, 7, 0, 0, 32'h55);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_vec++;
            if (bus.instr_ready !== 1'b0 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL busy_c%0d: got ready=%b busy=%b required 0 1", k, bus.instr_ready, busy);
            end
            if (k == 3) begin
                n_vec++;
                if (bus.done_valid !== 1'b1 || bus.done_rd !== 3'd1 || bus.done_value !== 32'h11) begin
                    n_err++;
                    $display("FAIL busy_done: got dv=%b rd=%0d val=%h required 1 1 00000011",
                             bus.done_valid, bus.done_rd, bus.done_value);
                end
                bus.instr_valid = 1'b0;
            end
        end
        $display("txn busy_hold first=ADDI R1 held=ADDI R7 (must be ignored)");
        model_rf[1] = 32'h11;
        @(negedge clk);
        n_vec++;
        if (bus.done_valid !== 1'b0 || bus.instr_ready !== 1'b1) begin
            n_err++;
            $display("FAIL busy_after: got dv=%b ready=%b required 0 1", bus.done_valid, bus.instr_ready);
        end
        check_regs("busy");
    endtask

    task automatic test_reset_mid();
        logic seen;
        exec(mk(6, 3, 0, 0, 32'h123), "pre_rst");
        bus.instr = mk(2, 3, 3, 3, 0);
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        @(negedge clk);            // DECODE
        @(negedge clk);            // EXECUTE
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int r = 0; r < 8; r++) model_rf[r] = 32'd0;
        $display("txn reset_in_execute");
        n_vec++;
        if (bus.instr_ready !== 1'b1 || busy !== 1'b0 || bus.done_valid !== 1'b0 ||
            bus.illegal !== 1'b0 || bus.alu_a !== 0 || bus.alu_b !== 0 || bus.alu_op !== 0 ||
            bus.done_rd !== 0 || bus.done_value !== 0) begin
            n_err++;
            $display("FAIL midrst_outputs: ready=%b busy=%b dv=%b ill=%b a=%h b=%h op=%0d required ready=1 others 0",
                     bus.instr_ready, busy, bus.done_valid, bus.illegal, bus.alu_a, bus.alu_b, bus.alu_op);
        end
        check_regs("midrst");
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done_valid !== 1'b0) seen = 1'b1;
        end
        n_vec++;
        if (seen) begin
            n_err++; $display("FAIL midrst_no_done: got done_valid=1 required 0");
        end
    endtask

    task automatic test_random();
        logic [31:0] w;
        for (int i = 0; i < 40; i++) begin
            w = mk(int'($urandom_range(2, 7)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : int'($urandom));
            exec(w, "rand");
        end
        check_regs("rand");
    endtask

    initial begin
        test_reset();
        test_add();
        test_subi_eq();
        test_back_to_back();
        test_illegal();
        test_r0_and_busy();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
